// File: rtl/spi_slave_ctrl_if.sv
// rtl/spi_slave_ctrl_if.sv - conditioned SPI inputs, register memory port and MISO pad signals
// Ports (slave modport, as seen by spi_slave_ctrl):
//   in : cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata
//   out: mem_addr, mem_wdata, mem_we, miso, miso_oe, busy
interface spi_slave_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              cs_cond;
  logic              sclk_pos;
  logic              sclk_neg;
  logic              mosi_cond;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              miso;
  logic              miso_oe;
  logic              busy;

  modport slave (
    input  cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata,
    output mem_addr, mem_wdata, mem_we, miso, miso_oe, busy
  );

  modport master (
    output cs_cond, sclk_pos, sclk_neg, mosi_cond, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, miso, miso_oe, busy
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode-0 slave frame sequencer (address, R/W, data) driving register memory and MISO
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : spi_slave_ctrl_if.slave (conditioned CS/SCLK edges/MOSI in; memory port, MISO, MISO enable, busy out)
module spi_slave_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_ctrl_if.slave   bus
);

  localparam int MAX_BITS = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READ_LOAD,
    READ_SEND,
    WRITE,
    COMMIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_sr_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              miso_q;
  logic              miso_oe_q;

  logic abort;
  logic addr_last;
  logic data_last;

  // CS deassertion wins over everything else in the same cycle, including a final SCLK edge.
  assign abort     = (state_q != IDLE) && bus.cs_cond;
  // addr_last fires on the R/W bit: ADDR_W address bits already counted.
  assign addr_last = bus.sclk_pos && (cnt_q == CNT_W'(ADDR_W));
  assign data_last = bus.sclk_pos && (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!bus.cs_cond) state_d = ADDR;
      ADDR:      if (addr_last) state_d = bus.mosi_cond ? READ_LOAD : WRITE;
      READ_LOAD: state_d = READ_SEND;
      READ_SEND: if (data_last) state_d = DONE;
      WRITE:     if (data_last) state_d = COMMIT;
      COMMIT:    state_d = DONE;
      DONE:      state_d = DONE;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_sr_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= 1'b0;
      if (abort) begin
        cnt_q     <= '0;
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: cnt_q <= '0;
          ADDR: begin
            if (bus.sclk_pos) begin
              addr_sr_q <= (addr_sr_q << 1) | ADDR_W'(bus.mosi_cond);
              if (addr_last) begin
                // The shift register still holds only the address bits; the R/W bit is live on mosi_cond.
                mem_addr_q <= addr_sr_q;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          READ_LOAD: begin
            tx_q      <= bus.mem_rdata;
            miso_oe_q <= 1'b1;
          end
          READ_SEND: begin
            if (bus.sclk_neg) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= tx_q << 1;
            end
            if (bus.sclk_pos) cnt_q <= data_last ? '0 : cnt_q + CNT_W'(1);
          end
          WRITE: begin
            if (bus.sclk_pos) begin
              rx_q <= (rx_q << 1) | DATA_W'(bus.mosi_cond);
              if (data_last) begin
                // Strobe and data are registered together so mem_we is high for the COMMIT cycle only.
                mem_wdata_q <= (rx_q << 1) | DATA_W'(bus.mosi_cond);
                mem_we_q    <= 1'b1;
                cnt_q       <= '0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.miso      = miso_q;
  assign bus.miso_oe   = miso_oe_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - directed self-checking bench for spi_slave_ctrl
module tb_spi_slave_ctrl;

  logic clk;
  logic rst_n;
  logic [7:0] mem [0:127];
  int n_tests;
  int n_fail;
  int we_count;

  spi_slave_ctrl_if #(.ADDR_W(7), .DATA_W(8)) bus ();

  spi_slave_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.mem_rdata = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) we_count <= we_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pos_pulse(input logic b);
    bus.mosi_cond = b;
    bus.sclk_pos  = 1'b1;
    tick();
    bus.sclk_pos  = 1'b0;
  endtask

  task automatic neg_pulse();
    bus.sclk_neg = 1'b1;
    tick();
    bus.sclk_neg = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    neg_pulse();
    idle(2);
    pos_pulse(b);
    idle(2);
  endtask

  // Full write frame; leaves the DUT in DONE with cs_cond still low.
  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input string tag);
    logic [15:0] f;
    int wc;
    f = {a, 1'b0, d};
    bus.cs_cond = 1'b0;
    tick();
    wc = we_count;
    for (int i = 15; i >= 1; i--) send_bit(f[i]);
    neg_pulse();
    idle(2);
    chk({tag, "_we_before"}, {31'd0, bus.mem_we}, 32'd0);
    pos_pulse(f[0]);
    chk({tag, "_we_pulse"}, {31'd0, bus.mem_we}, 32'd1);
    chk({tag, "_addr"}, {25'd0, bus.mem_addr}, {25'd0, a});
    chk({tag, "_wdata"}, {24'd0, bus.mem_wdata}, {24'd0, d});
    tick();
    chk({tag, "_we_drop"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_we_count"}, we_count - wc, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
  endtask

  // Full read frame followed by CS release.
  task automatic do_read(input logic [6:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] h;
    int wc;
    h = {a, 1'b1};
    bus.cs_cond = 1'b0;
    tick();
    wc = we_count;
    for (int i = 7; i >= 1; i--) send_bit(h[i]);
    neg_pulse();
    idle(2);
    pos_pulse(h[0]);
    chk({tag, "_oe_load"}, {31'd0, bus.miso_oe}, 32'd0);
    tick();
    chk({tag, "_oe_on"}, {31'd0, bus.miso_oe}, 32'd1);
    chk({tag, "_addr"}, {25'd0, bus.mem_addr}, {25'd0, a});
    tick();
    for (int i = 7; i >= 0; i--) begin
      neg_pulse();
      chk($sformatf("%s_miso%0d", tag, i), {31'd0, bus.miso}, {31'd0, exp[i]});
      idle(2);
      pos_pulse(1'b0);
      idle(2);
    end
    chk({tag, "_no_we"}, we_count - wc, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
    bus.cs_cond = 1'b1;
    tick();
    chk({tag, "_oe_off"}, {31'd0, bus.miso_oe}, 32'd0);
    chk({tag, "_busy_off"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] f;
    int wc;
    n_tests  = 0;
    n_fail   = 0;
    we_count = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i);
    mem[7'h15]   = 8'hA3;
    rst_n        = 1'b0;
    bus.cs_cond  = 1'b0;
    bus.sclk_pos = 1'b0;
    bus.sclk_neg = 1'b0;
    bus.mosi_cond = 1'b0;

    // Reset with CS low and SCLK activity
    bus.sclk_pos = 1'b1;
    tick();
    bus.sclk_pos = 1'b0;
    bus.sclk_neg = 1'b1;
    tick();
    bus.sclk_neg = 1'b0;
    chk("rst_addr", {25'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_miso", {31'd0, bus.miso}, 32'd0);
    chk("rst_oe", {31'd0, bus.miso_oe}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_busy", {31'd0, bus.busy}, 32'd1);

    // Write 0x2A <- 0xC5, then extra edges in DONE
    do_write(7'h2A, 8'hC5, "wr1");
    wc = we_count;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    chk("extra_no_we", we_count - wc, 32'd0);
    chk("extra_wdata", {24'd0, bus.mem_wdata}, 32'hC5);
    bus.cs_cond = 1'b1;
    tick();
    chk("wr1_busy_off", {31'd0, bus.busy}, 32'd0);

    // Stray edges while deselected
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("stray_busy", {31'd0, bus.busy}, 32'd0);
    chk("stray_no_we", we_count - wc, 32'd0);
    chk("stray_addr", {25'd0, bus.mem_addr}, 32'h2A);

    // Abort after 12 sclk_pos
    f = {7'h33, 1'b0, 8'hFF};
    bus.cs_cond = 1'b0;
    tick();
    for (int i = 15; i >= 4; i--) send_bit(f[i]);
    bus.cs_cond = 1'b1;
    tick();
    chk("abort12_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort12_oe", {31'd0, bus.miso_oe}, 32'd0);
    chk("abort12_no_we", we_count - wc, 32'd0);

    // Abort coinciding with the final sclk_pos
    bus.cs_cond = 1'b0;
    tick();
    for (int i = 15; i >= 1; i--) send_bit(f[i]);
    neg_pulse();
    idle(2);
    bus.cs_cond = 1'b1;
    pos_pulse(f[0]);
    chk("abort16_we", {31'd0, bus.mem_we}, 32'd0);
    chk("abort16_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("abort16_no_we", we_count - wc, 32'd0);
    chk("abort16_wdata", {24'd0, bus.mem_wdata}, 32'hC5);

    // Recovery write
    do_write(7'h01, 8'h7E, "wr2");
    bus.cs_cond = 1'b1;
    tick();

    // Read 0x15 -> 0xA3
    do_read(7'h15, 8'hA3, "rd1");
    chk("rd1_addr_hold", {25'd0, bus.mem_addr}, 32'h15);

    // Reset during read data phase
    f = {8'b0, 7'h15, 1'b1};
    bus.cs_cond = 1'b0;
    tick();
    for (int i = 7; i >= 0; i--) send_bit(f[i]);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    chk("mid_oe_before", {31'd0, bus.miso_oe}, 32'd1);
    chk("mid_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_miso", {31'd0, bus.miso}, 32'd0);
    chk("mid_rst_oe", {31'd0, bus.miso_oe}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_addr", {25'd0, bus.mem_addr}, 32'd0);
    bus.cs_cond = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("mid_idle_busy", {31'd0, bus.busy}, 32'd0);
    do_read(7'h15, 8'hA3, "rd2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- Sequences the SPI slave datapath downstream of the three input conditioners (CS, SCLK, MOSI).
- Consumes the conditioned chip select, the SCLK edge pulses and the conditioned MOSI level.
- Decodes a fixed frame of address, R/W bit and data, then issues one write to, or one read from, the slave register memory.
- Drives MISO and its output enable; sits between the conditioners and the memory/tri-state pad.

Parameters:
ADDR_W, 7, address bits per frame
DATA_W, 8, data bits per frame

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
cs_cond  input  1  conditioned chip select, active-low
sclk_pos  input  1  one-cycle pulse per conditioned SCLK rising edge
sclk_neg  input  1  one-cycle pulse per conditioned SCLK falling edge
mosi_cond  input  1  conditioned MOSI level
mem_rdata  input  DATA_W  memory read data, combinational from mem_addr
mem_addr  output  ADDR_W  latched frame address
mem_wdata  output  DATA_W  latched write data
mem_we  output  1  one-cycle write strobe
miso  output  1  serial read data
miso_oe  output  1  MISO pad enable
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values (rst_n=0 at a clk edge): state IDLE; mem_addr=0; mem_wdata=0; mem_we=0; miso=0; miso_oe=0; busy=0; bit counter and shift registers cleared.
- SPI mode: mode 0. MOSI sampled on sclk_pos, MSB first. MISO updated on sclk_neg.
- Frame layout: ADDR_W address bits, then R/W bit (1=read, 0=write), then DATA_W data bits.
- Timing constraint: SCLK half-period must be at least 3 clk cycles.
- Edge pulses: sclk_pos and sclk_neg are processed independently even if both occur in the same cycle.
- IDLE: all SCLK edges ignored. cs_cond=0 moves to ADDR next cycle and clears the counter.
- ADDR: on each sclk_pos, shift mosi_cond into the address shift register and increment the counter. On the (ADDR_W+1)th sclk_pos:
  - mem_addr <= upper ADDR_W bits; rw <= last bit; counter cleared.
  - Next state is READ_LOAD if rw=1, WRITE if rw=0.
- READ_LOAD (exactly one cycle): tx <= mem_rdata; miso_oe <= 1; go to READ_SEND. miso is not changed in this cycle.
- READ_SEND:
  - On sclk_neg: miso <= tx[DATA_W-1]; tx <= tx << 1.
  - On sclk_pos: increment counter. On the DATA_W-th sclk_pos, go to DONE.
  - Net effect: the first sclk_neg after the R/W bit presents the data MSB.
- WRITE: on each sclk_pos, shift mosi_cond into the receive register. On the DATA_W-th sclk_pos, go to COMMIT.
- COMMIT (exactly one cycle): mem_wdata <= rx and mem_we=1 in this cycle; go to DONE. mem_we is high for exactly one clk per completed write frame.
- DONE: all SCLK edges ignored; mem_we stays 0. miso_oe holds its value; miso holds its last driven value. cs_cond=1 moves to IDLE.
- Abort: cs_cond=1 in any non-IDLE state moves to IDLE next cycle, clears miso_oe, miso and the counter, and produces no mem_we.
  - Abort takes priority over a simultaneous final sclk_pos, so a write is never committed in that case.
- Reset mid-frame: overrides everything and applies the reset values at that edge; the next frame starts from IDLE normally.
- busy: high in every state except IDLE.
- mem_addr: holds its value between frames; updates only at end of ADDR.
- Arithmetic: bit counter width is clog2(max(ADDR_W+1, DATA_W)+1). No wrap is possible because the counter is cleared on every phase change.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with cs_cond=0 and sclk toggling -> all outputs 0, busy=0. Release -> ADDR is entered on the next cycle.
- Write frame: addr 0x2A, rw=0, data 0xC5 (16 sclk_pos) -> exactly one mem_we pulse, 1 cycle after the 16th sclk_pos, with mem_addr=0x2A and mem_wdata=0xC5.
- Read frame: addr 0x15, rw=1, mem_rdata=0xA3 -> miso_oe=1 two cycles after the 8th sclk_pos. miso is 1,0,1,0,0,0,1,1 after successive sclk_neg. mem_we stays 0. miso_oe=0 one cycle after cs_cond=1.
- Abort: write frame with cs_cond=1 after 12 sclk_pos -> no mem_we; busy=0 on the next cycle. A following full write of 0x01/0x7E commits correctly.
- Extra and stray edges: 20 extra SCLK edges after a completed write -> no second mem_we. SCLK edges while cs_cond=1 -> no state change, busy=0.
- Reset mid-read: rst_n=0 after 4 data bits shifted -> miso=0, miso_oe=0, busy=0 at that edge. A subsequent read of addr 0x15 returns all 8 bits of 0xA3 correctly.
